// File: rtl/fault_campaign_pkg.sv
// Shared types and constants for the fault-injection campaign controller.
// Optional feature macro: FAULT_CAMPAIGN_BASELINE_EN (fault-free baseline step).
package fault_campaign_pkg;

    localparam int ADDR_W           = 4;   // width of fault_bit_addr and the bit index
    localparam int COUNT_W          = 4;   // width of detect_count
    localparam int LAT_W            = 3;   // latency counter, covers CHECK_LAT 0..7
    localparam int DEFAULT_NUM_BITS = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BASE,
        ST_INJECT,
        ST_GAP,
        ST_DONE
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value);
        return (value == {COUNT_W{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/fault_campaign_if.sv
// Handshake and result bundle between a campaign requester and the controller.
// Optional feature macro: FAULT_CAMPAIGN_BASELINE_EN (drives false_pos when set).
interface fault_campaign_if
    import fault_campaign_pkg::*;
#(
    parameter int NUM_BITS = DEFAULT_NUM_BITS
);
    logic                start;
    logic                abort;
    logic                error_detected;
    logic [ADDR_W-1:0]   fault_bit_addr;
    logic                fault_en;
    logic                busy;
    logic                done;
    logic [NUM_BITS-1:0] miss_mask;
    logic [COUNT_W-1:0]  detect_count;
    logic                false_pos;

    // Requester side: issues commands, observes injector drive and results.
    modport master (
        output start, abort, error_detected,
        input  fault_bit_addr, fault_en, busy, done, miss_mask, detect_count, false_pos
    );

    // Controller side.
    modport slave (
        input  start, abort, error_detected,
        output fault_bit_addr, fault_en, busy, done, miss_mask, detect_count, false_pos
    );
endinterface

// File: rtl/fault_campaign_ctrl.sv
// Sweeps a single-bit fault across every code-word position, waits CHECK_LAT
// cycles per injection for the Berger checker, and records which faults escaped.
// Optional feature macro: FAULT_CAMPAIGN_BASELINE_EN -- adds a fault-free BASE
// step before the sweep and makes false_pos live; otherwise false_pos is 0.
module fault_campaign_ctrl
    import fault_campaign_pkg::*;
#(
    parameter int NUM_BITS  = DEFAULT_NUM_BITS,
    parameter int CHECK_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    fault_campaign_if.slave bus
);

    localparam logic [LAT_W-1:0]  LAST_CNT = LAT_W'(CHECK_LAT);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_BITS - 1);

    state_t              state, state_next;
    logic [LAT_W-1:0]    lat_cnt;
    logic [ADDR_W-1:0]   bit_idx, idx_next;
    logic                last_cycle;
    logic                take_start;
    logic                sample_inject;
    logic                fault_en_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [NUM_BITS-1:0] miss_q;
    logic [COUNT_W-1:0]  count_q;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state decode, index advance and result-sampling strobes.
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_next    = state;
        idx_next      = bit_idx;
        take_start    = 1'b0;
        sample_inject = 1'b0;
        last_cycle    = (lat_cnt == LAST_CNT);
        unique case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    take_start = 1'b1;
                    idx_next   = '0;
`ifdef FAULT_CAMPAIGN_BASELINE_EN
                    state_next = ST_BASE;
`else
                    state_next = ST_INJECT;
`endif
                end
            end
            ST_BASE: begin
                if (bus.abort)      state_next = ST_IDLE;
                else if (last_cycle) state_next = ST_INJECT;
            end
            ST_INJECT: begin
                if (bus.abort) begin
                    state_next = ST_IDLE;
                end else if (last_cycle) begin
                    sample_inject = 1'b1;
                    if (bit_idx == LAST_IDX) begin
                        state_next = ST_DONE;
                    end else begin
                        idx_next   = bit_idx + 1'b1;
                        state_next = ST_GAP;
                    end
                end
            end
            ST_GAP:  state_next = bus.abort ? ST_IDLE : ST_INJECT;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Latency counter, bit index, registered injector drive and result capture.
    // NOTE: miss_mask is a plain flop vector, so it is cleared by reset like any other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_cnt    <= '0;
            bit_idx    <= '0;
            fault_en_q <= 1'b0;
            addr_q     <= '0;
            miss_q     <= '0;
            count_q    <= '0;
        end else begin
            // Restart the dwell count on every state entry.
            lat_cnt    <= (state_next != state) ? '0 : lat_cnt + 1'b1;
            bit_idx    <= idx_next;
            fault_en_q <= (state_next == ST_INJECT);
            if (state_next == ST_INJECT) addr_q <= idx_next;
            if (take_start) begin
                miss_q  <= '0;
                count_q <= '0;
            end else if (sample_inject) begin
                if (bus.error_detected) count_q         <= sat_inc(count_q);
                else                    miss_q[bit_idx] <= 1'b1;
            end
        end
    end

`ifdef FAULT_CAMPAIGN_BASELINE_EN
    logic sample_base;
    logic false_pos_q;

    assign sample_base = (state == ST_BASE) && !bus.abort && last_cycle;

    // Baseline capture: any error flagged with no fault injected is a false positive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              false_pos_q <= 1'b0;
        else if (take_start)  false_pos_q <= 1'b0;
        else if (sample_base) false_pos_q <= bus.error_detected;
    end

    assign bus.false_pos = false_pos_q;
`else
    assign bus.false_pos = 1'b0;
`endif

    assign bus.fault_en       = fault_en_q;
    assign bus.fault_bit_addr = addr_q;
    assign bus.busy           = (state != ST_IDLE);
    assign bus.done           = (state == ST_DONE);
    assign bus.miss_mask      = miss_q;
    assign bus.detect_count   = count_q;

endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// Self-checking bench for fault_campaign_ctrl. A delayed decoder model answers
// each injection from a random per-bit detection pattern; expected traces and
// results come from the campaign timing rules written as plain arithmetic.
// Honours FAULT_CAMPAIGN_BASELINE_EN the same way the design does.
module tb_fault_campaign_ctrl;
    import fault_campaign_pkg::*;

    localparam int N    = 12;
    localparam int CL   = 1;
    localparam int STEP = CL + 2;     // inject dwell plus one gap cycle
`ifdef FAULT_CAMPAIGN_BASELINE_EN
    localparam int BASE_CYC = CL + 1;
    localparam bit HAS_BASE = 1'b1;
`else
    localparam int BASE_CYC = 0;
    localparam bit HAS_BASE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fault_campaign_if #(.NUM_BITS(N)) bus ();

    fault_campaign_ctrl #(.NUM_BITS(N), .CHECK_LAT(CL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Decoder model: reacts to the injector drive CL cycles late.
    logic [15:0] det_pat  = '0;
    logic        base_err = 1'b0;
    logic        pipe_en   [CL];
    logic [3:0]  pipe_addr [CL];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CL; i++) begin
                pipe_en[i]   <= 1'b0;
                pipe_addr[i] <= '0;
            end
        end else begin
            pipe_en[0]   <= bus.fault_en;
            pipe_addr[0] <= bus.fault_bit_addr;
            for (int i = 1; i < CL; i++) begin
                pipe_en[i]   <= pipe_en[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
            end
        end
    end

    always_comb bus.error_detected = pipe_en[CL-1] ? det_pat[pipe_addr[CL-1]] : base_err;

    task automatic test_reset();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.done, bus.fault_en, bus.fault_bit_addr, bus.miss_mask,
             bus.detect_count, bus.false_pos} !== '0)
            $display("FAIL reset_outputs: busy=%b done=%b en=%b addr=%0d miss=%h cnt=%0d fp=%b required all 0",
                     bus.busy, bus.done, bus.fault_en, bus.fault_bit_addr, bus.miss_mask,
                     bus.detect_count, bus.false_pos);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One full campaign: compare every cycle against the expected schedule, then the results.
    task automatic run_campaign(input logic [N-1:0] det, input logic berr, input string tag);
        int          exp_done, k, done_at;
        int          en_err, addr_err, busy_err, done_err;
        logic        exp_en;
        logic [N-1:0] exp_miss;
        logic [3:0]  exp_cnt;
        logic        exp_fp;
        det_pat  = {4'b0, det};
        base_err = berr;
        exp_done = BASE_CYC + N * STEP;
        en_err = 0; addr_err = 0; busy_err = 0; done_err = 0; done_at = -1;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int c = 1; c <= exp_done + 1; c++) begin
            @(negedge clk);
            k      = c - 1 - BASE_CYC;
            exp_en = (k >= 0) && (k < N * STEP) && ((k % STEP) <= CL);
            if (bus.fault_en !== exp_en) en_err++;
            if (exp_en && bus.fault_bit_addr !== 4'(k / STEP)) addr_err++;
            if (bus.busy !== (c <= exp_done)) busy_err++;
            if (bus.done !== (c == exp_done)) done_err++;
            if (bus.done === 1'b1 && done_at < 0) done_at = c;
        end
        exp_miss = ~det;
        exp_cnt  = ($countones(det) > 15) ? 4'd15 : 4'($countones(det));
        exp_fp   = HAS_BASE ? berr : 1'b0;

        n_checks++;
        if (en_err != 0) $display("FAIL %s fault_en_trace: %0d bad cycles, required 0", tag, en_err);
        else n_pass++;
        n_checks++;
        if (addr_err != 0) $display("FAIL %s addr_trace: %0d bad cycles, required 0", tag, addr_err);
        else n_pass++;
        n_checks++;
        if (busy_err != 0) $display("FAIL %s busy_trace: %0d bad cycles, required 0", tag, busy_err);
        else n_pass++;
        n_checks++;
        if (done_at != exp_done) $display("FAIL %s done_cycle: got %0d required %0d", tag, done_at, exp_done);
        else n_pass++;
        n_checks++;
        if (done_err != 0) $display("FAIL %s done_pulse: %0d bad cycles, required 0", tag, done_err);
        else n_pass++;
        n_checks++;
        if (bus.miss_mask !== exp_miss) $display("FAIL %s miss_mask: got %h required %h", tag, bus.miss_mask, exp_miss);
        else n_pass++;
        n_checks++;
        if (bus.detect_count !== exp_cnt) $display("FAIL %s detect_count: got %0d required %0d", tag, bus.detect_count, exp_cnt);
        else n_pass++;
        n_checks++;
        if (bus.false_pos !== exp_fp) $display("FAIL %s false_pos: got %b required %b", tag, bus.false_pos, exp_fp);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.miss_mask, bus.detect_count, bus.false_pos, bus.busy} !== {exp_miss, exp_cnt, exp_fp, 1'b0})
            $display("FAIL %s results_hold: miss=%h cnt=%0d fp=%b busy=%b required %h %0d %b 0",
                     tag, bus.miss_mask, bus.detect_count, bus.false_pos, bus.busy, exp_miss, exp_cnt, exp_fp);
        else n_pass++;
    endtask

    task automatic test_directed();
        run_campaign({N{1'b1}}, 1'b0, "all_detect");
        run_campaign(12'h555, 1'b1, "even_detect");
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++)
            run_campaign(N'($urandom), 1'($urandom), $sformatf("random%0d", r));
    endtask

    task automatic test_start_abort_together();
        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(posedge clk);
        #1 begin bus.start = 1'b0; bus.abort = 1'b0; end
        n_checks++;
        if (bus.busy !== 1'b1) $display("FAIL start_wins: busy=%b required 1", bus.busy);
        else n_pass++;
        @(negedge clk);
        bus.abort = 1'b1;
        @(posedge clk);
        #1 bus.abort = 1'b0;
        n_checks++;
        if ({bus.busy, bus.fault_en} !== 2'b00) $display("FAIL abort_idle: busy=%b en=%b required 0 0", bus.busy, bus.fault_en);
        else n_pass++;
    endtask

    task automatic test_abort();
        logic [N-1:0] det;
        bit           found;
        bit           saw_done;
        det      = N'($urandom);
        det_pat  = {4'b0, det};
        base_err = 1'b0;
        found    = 1'b0;
        saw_done = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (bus.fault_en === 1'b1 && bus.fault_bit_addr === 4'd4) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            $display("FAIL abort_reach_bit4: timeout=1 required 0");
            return;
        end
        n_pass++;
        bus.abort = 1'b1;
        @(posedge clk);
        #1 bus.abort = 1'b0;
        n_checks++;
        if ({bus.busy, bus.fault_en} !== 2'b00) $display("FAIL abort_next: busy=%b en=%b required 0 0", bus.busy, bus.fault_en);
        else n_pass++;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.fault_en === 1'b1) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done) $display("FAIL abort_no_done: activity=1 required 0");
        else n_pass++;
        n_checks++;
        if ({bus.miss_mask, bus.detect_count} !== {{(N-4){1'b0}}, ~det[3:0], 4'($countones(det[3:0]))})
            $display("FAIL abort_partial: miss=%h cnt=%0d required %h %0d", bus.miss_mask, bus.detect_count,
                     {{(N-4){1'b0}}, ~det[3:0]}, $countones(det[3:0]));
        else n_pass++;
    endtask

    task automatic test_busy_start_and_rst();
        bit   found;
        bit   activity;
        det_pat  = 16'h0FFE;          // bit 0 escapes so results are non-zero before reset
        base_err = 1'b0;
        found    = 1'b0;
        activity = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (bus.fault_en === 1'b1 && bus.fault_bit_addr === 4'd3) found = 1'b1;
        end
        if (found) begin
            bus.start = 1'b1;         // re-request while busy
            @(posedge clk);
            #1 bus.start = 1'b0;
            found = 1'b0;
            for (int c = 0; c < 20 && !found; c++) begin
                @(negedge clk);
                if (bus.fault_en === 1'b1 && bus.fault_bit_addr !== 4'd3) found = 1'b1;
            end
        end
        n_checks++;
        if (!found || bus.fault_bit_addr !== 4'd4)
            $display("FAIL busy_start_ignored: next addr=%0d found=%b required 4 1", bus.fault_bit_addr, found);
        else n_pass++;
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clk);
            if (bus.busy === 1'b1 && bus.fault_en === 1'b0 && bus.fault_bit_addr === 4'd5) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            $display("FAIL rst_reach_gap: timeout=1 required 0");
            return;
        end
        n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.busy, bus.done, bus.fault_en, bus.fault_bit_addr, bus.miss_mask,
             bus.detect_count, bus.false_pos} !== '0)
            $display("FAIL rst_mid_gap: busy=%b en=%b addr=%0d miss=%h cnt=%0d required all 0",
                     bus.busy, bus.fault_en, bus.fault_bit_addr, bus.miss_mask, bus.detect_count);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 2 * N * STEP; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1 || bus.fault_en === 1'b1) activity = 1'b1;
        end
        n_checks++;
        if (activity) $display("FAIL rst_no_done: activity=1 required 0");
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_abort_together();
        test_abort();
        test_busy_start_and_rst();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time=%0t required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fault_campaign_ctrl.md
FAULT_CAMPAIGN_CTRL -- requirements
Module: fault_campaign_ctrl

Interface
REQ-001 Parameter NUM_BITS, default 12, is the code-word width swept; one injection is made per bit position.
REQ-002 Parameter CHECK_LAT, default 1, is the number of cycles from fault_en/fault_bit_addr change to valid error_detected; legal range 0..7.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  campaign request; sampled only in IDLE.
REQ-006 abort  input  1  terminate campaign; effective in any non-IDLE state.
REQ-007 error_detected  input  1  checker flag from the downstream Berger decoder.
REQ-008 fault_bit_addr  output  4  bit position driven to the fault injector, registered.
REQ-009 fault_en  output  1  injector enable, registered.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse on campaign completion.
REQ-012 miss_mask  output  NUM_BITS  bit i set = fault on bit i was not detected.
REQ-013 detect_count  output  4  number of injected faults detected, saturating at 15.
REQ-014 false_pos  output  1  error_detected seen during the fault-free baseline step.

Function
REQ-015 States: IDLE, BASE, INJECT, GAP, DONE.
REQ-016 IDLE: fault_en=0, fault_bit_addr held; start=1 -> clear miss_mask, detect_count, false_pos, bit index := 0, go to BASE (baseline enabled) or INJECT.
REQ-017 BASE: fault_en=0 for CHECK_LAT+1 cycles; on the last cycle, sample error_detected into false_pos; then go to INJECT.
REQ-018 INJECT: fault_en=1, fault_bit_addr=bit index for CHECK_LAT+1 cycles; on the last cycle, sample error_detected: 1 -> detect_count++ (saturating), 0 -> miss_mask[index] := 1.
REQ-019 After INJECT: index == NUM_BITS-1 -> DONE; otherwise index++ and go to GAP.
REQ-020 GAP: exactly one cycle with fault_en=0 so the decoder settles; then INJECT.
REQ-021 DONE: done=1 for one cycle, fault_en=0, then IDLE; the result outputs hold until the next accepted start.
REQ-022 start while busy=1 is ignored; start and abort asserted together in IDLE: start wins and abort is ignored.
REQ-023 abort in BASE/INJECT/GAP/DONE: next cycle IDLE, fault_en=0, no done pulse, and the partial results are retained.
REQ-024 Latency: with baseline disabled, done asserts NUM_BITS*(CHECK_LAT+2) cycles after the start-sampling edge; baseline adds CHECK_LAT+1 cycles.
REQ-025 Only one bit is ever faulted at a time; fault_en is never high in BASE, GAP, DONE or IDLE.

Reset
REQ-026 rst=1 forces IDLE, fault_en=0, fault_bit_addr=0, busy=0, done=0, miss_mask=0, detect_count=0, false_pos=0, and clears the internal latency counter and index, asynchronously.
REQ-027 rst mid-campaign discards all results; no done pulse is produced.

Configuration
REQ-028 Macro FAULT_CAMPAIGN_BASELINE_EN defined: the BASE state is present and false_pos is live.
REQ-029 Macro absent: BASE is unreachable, IDLE goes directly to INJECT, and false_pos is tied to 0.

Structure
REQ-030 Shared package fault_campaign_pkg holds the state enum, the 4-bit address/count width constants and the default NUM_BITS=12.
REQ-031 Single module; no sub-module needed, and the latency counter and index are inline registers.

Verification
REQ-032 Baseline off, CHECK_LAT=1, error_detected tied 1, start pulse -> fault_bit_addr steps 0..11, done at cycle 36, detect_count=12, miss_mask=0.
REQ-033 error_detected=1 only when fault_bit_addr is even -> miss_mask=12'hAAA, detect_count=6.
REQ-034 Baseline on, error_detected=1 during BASE -> false_pos=1, done at cycle 38.
REQ-035 abort asserted during INJECT of bit 4 -> IDLE next cycle, fault_en=0, no done pulse, and miss_mask/detect_count reflect bits 0..3 only.
REQ-036 rst asserted mid-GAP, plus start re-pulsed while busy -> all outputs 0 immediately on rst; a start while busy does not restart the index.
